memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/cpu_types_pkg.sv | 36 +++
 rtl/arb_select.sv | 35 +++
 rtl/memory_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU types: memory word, RAM handshake state, memory
//                arbiter FSM states and arbiter requester indices.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Handshake state reported by the RAM model / controller
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERR   = 2'd2
    } arbstate_t;

    // Requester indices; bit 1 marks the instruction class, bit 0 the core
    localparam logic [1:0] REQ_D0 = 2'd0;
    localparam logic [1:0] REQ_D1 = 2'd1;
    localparam logic [1:0] REQ_I0 = 2'd2;
    localparam logic [1:0] REQ_I1 = 2'd3;

    localparam int NUM_REQ = 4;

endpackage
`default_nettype wire

// File: rtl/arb_select.sv
`default_nettype none
// ============================================================================
//  Module      : arb_select
//  Description : Combinational winner selection for the memory arbiter. Data
//                requests beat instruction requests; inside a class the core
//                named by rr wins, the other core only when rr is silent.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_select
    import cpu_types_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr,
    output logic [1:0]         winner,
    output logic               valid
);

    logic [1:0] w_dreq;
    logic [1:0] w_ireq;

    // Class priority first, then round-robin pointer within the class
    always_comb begin
        w_dreq = {req[REQ_D1], req[REQ_D0]};
        w_ireq = {req[REQ_I1], req[REQ_I0]};
        valid  = |req;
        winner = REQ_D0;
        if (|w_dreq) begin
            winner = {1'b0, (w_dreq[rr] ? rr : ~rr)};
        end else if (|w_ireq) begin
            winner = {1'b1, (w_ireq[rr] ? rr : ~rr)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Shares one RAM port between the instruction and data caches
//                of two cores. One access in flight at a time; the RAM side
//                is driven combinationally from the owner's live request.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CORES = 2
)
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic [CORES-1:0] iREN,
    input  word_t            iaddr  [CORES],
    output logic [CORES-1:0] iwait,
    output word_t            iload  [CORES],
    input  logic [CORES-1:0] dREN,
    input  logic [CORES-1:0] dWEN,
    input  word_t            daddr  [CORES],
    input  word_t            dstore [CORES],
    output logic [CORES-1:0] dwait,
    output word_t            dload  [CORES],
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate
);

    arbstate_t          r_state;
    arbstate_t          w_next_state;
    logic [1:0]         r_owner;
    logic               r_rr;
    logic [NUM_REQ-1:0] w_req;
    logic [1:0]         w_win;
    logic               w_valid;
    logic               w_own_core;
    logic               w_own_is_i;
    logic               w_own_req;
    logic               w_done;

    // Requester vector in REQ_D0..REQ_I1 order
    always_comb begin
        w_req      = {iREN, (dREN | dWEN)};
        w_own_core = r_owner[0];
        w_own_is_i = r_owner[1];
        w_own_req  = w_req[r_owner];
    end

    arb_select u_arb_select (
        .req    (w_req),
        .rr     (r_rr),
        .winner (w_win),
        .valid  (w_valid)
    );

    // Next-state and all outputs; everything idles at zero / wait high
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        iwait        = '1;
        dwait        = '1;
        iload        = '{default: '0};
        dload        = '{default: '0};
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (w_own_is_i) begin
                    ramaddr = iaddr[w_own_core];
                    ramREN  = iREN[w_own_core];
                end else begin
                    ramaddr  = daddr[w_own_core];
                    ramstore = dstore[w_own_core];
                    // a write takes precedence over a simultaneous read
                    ramWEN   = dWEN[w_own_core];
                    ramREN   = dREN[w_own_core] & ~dWEN[w_own_core];
                end
                if (!w_own_req) begin
                    // owner withdrew: drop the access, no completion
                    w_next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                    if (w_own_is_i) begin
                        iwait[w_own_core] = 1'b0;
                        iload[w_own_core] = ramload;
                    end else begin
                        dwait[w_own_core] = 1'b0;
                        dload[w_own_core] = ramload;
                    end
                end else if (ramstate == ERROR) begin
                    w_next_state = ERR;
                end
            end
            ERR: begin
                // one dead cycle with the RAM strobes low, then re-arbitrate
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, owner latch and round-robin pointer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_owner <= REQ_D0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_valid) begin
                r_owner <= w_win;
            end
            if (w_done) begin
                r_rr <= ~r_rr;
            end
        end
    end

endmodule
`default_nettype wire
